// File: rtl/nan_pkg.sv
// Shared fp3 encoding, transfer mode and the nan_op lane operator.
// An fp3 value is {sign, class}.
package nan_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'b00,
        CLS_ONE  = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } fp3_class_e;

    typedef enum logic {
        MODE_ELEMENTWISE = 1'b0,
        MODE_REDUCE      = 1'b1
    } mode_e;

    localparam logic [2:0] POS0 = 3'b000;
    localparam logic [2:0] POS1 = 3'b001;
    localparam logic [2:0] PINF = 3'b010;
    localparam logic [2:0] PNAN = 3'b011;
    localparam logic [2:0] NEG0 = 3'b100;
    localparam logic [2:0] NEG1 = 3'b101;
    localparam logic [2:0] NINF = 3'b110;
    localparam logic [2:0] NNAN = 3'b111;

    function automatic logic is_nan(input logic [2:0] x);
        return x[1:0] == CLS_NAN;
    endfunction

    // Priority matters: a NaN operand wins over the infinity rules.
    function automatic logic [2:0] nan_op(input logic [2:0] x, input logic [2:0] y);
        if (is_nan(x) || is_nan(y))
            return PINF;
        else if ((x == PINF && y == NINF) || (x == NINF && y == PINF))
            return PINF;
        else if (x == PINF || y == PINF)
            return PNAN;
        else
            return PINF;
    endfunction

endpackage

// File: rtl/nan_pipe_stage.sv
// One valid/ready register stage. The stage loads whenever it is empty or
// its downstream takes the current word; the parent derives upstream ready.
module nan_pipe_stage #(
    parameter int           W       = 12,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic load;

    assign load = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= RST_VAL;
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/nan_array_pipe.sv
// LANES-wide fp3 nan_op engine with elementwise and packet-reduce modes,
// followed by a STAGES-deep valid/ready output pipeline.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no packet open; next accepted beat starts one (mode sampled)
// ST_ACCUM | REDUCE packet open; acc folds in_a until the last beat
module nan_array_pipe
    import nan_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [3*LANES-1:0]   in_a,
    input  logic [3*LANES-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*LANES-1:0]   out_y,
    output logic [LANES-1:0]     out_bits,
    output logic                 err
);

    localparam int W = 3 * LANES;
    localparam logic [W-1:0] ALL_PINF = {LANES{PINF}};

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    logic [0:0]   state, state_nxt;
    logic [W-1:0] acc, acc_nxt;
    logic [W-1:0] op_ab, op_acc;
    logic [W-1:0] emit_data;
    logic         emit, err_set, accept;

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] vq;
    logic [W-1:0]      stg_d [STAGES+1];

    assign accept = in_valid && in_ready;

    always_comb begin
        op_ab  = '0;
        op_acc = '0;
        for (int i = 0; i < LANES; i++) begin
            op_ab[3*i +: 3]  = nan_op(in_a[3*i +: 3], in_b[3*i +: 3]);
            op_acc[3*i +: 3] = nan_op(acc[3*i +: 3], in_a[3*i +: 3]);
        end
    end

    // Mode only matters in IDLE; an open packet is always REDUCE.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        emit      = 1'b0;
        err_set   = 1'b0;
        emit_data = op_ab;
        if (accept) begin
            if (state == ST_IDLE) begin
                if (mode_e'(mode) == MODE_ELEMENTWISE) begin
                    emit = 1'b1;
                end else begin
                    acc_nxt = op_ab;
                    err_set = !in_first;
                    if (in_last)
                        emit = 1'b1;
                    else
                        state_nxt = ST_ACCUM;
                end
            end else begin
                if (in_first) begin
                    acc_nxt = op_ab;
                    err_set = 1'b1;
                end else begin
                    acc_nxt = op_acc;
                end
                emit_data = acc_nxt;
                if (in_last) begin
                    emit      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= ALL_PINF;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            if (err_set)
                err <= 1'b1;
        end
    end

    // Stage s may load when out_ready is high or any stage at or after s is
    // empty; computed from registered valids so there is no ready chain.
    assign rdy[STAGES] = out_ready;
    assign stg_d[0]    = emit_data;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        assign rdy[s] = out_ready || !(&vq[STAGES-1:s]);

        nan_pipe_stage #(
            .W       (W),
            .RST_VAL (ALL_PINF)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  ((s == 0) ? emit : vq[(s == 0) ? 0 : s-1]),
            .in_data   (stg_d[s]),
            .out_valid (vq[s]),
            .out_ready (rdy[s+1]),
            .out_data  (stg_d[s+1])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = vq[STAGES-1];
    assign out_y     = stg_d[STAGES];

    always_comb begin
        out_bits = '0;
        for (int i = 0; i < LANES; i++)
            out_bits[i] = is_nan(out_y[3*i +: 3]);
    end

endmodule
